// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//   Owns the program counter and the IF/ID pipeline register of the pipelined
//   core. The PC drives a combinational instruction memory, and the returned
//   word is captured into IF/ID.
//   - Hazard-unit stalls hold the PC and/or the IF/ID register.
//   - EX-stage branch redirects load the PC and flush IF/ID.
//   - On the EXIT word the controller stops fetching and drains the pipeline
//     with bubbles. After DRAIN_CYCLES edges it raises halted.
//   - Fetching a word beyond MEM_DEPTH raises fetch_fault and halted.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, the block adds saturating performance counters
//   perf_fetched and perf_stalls. When undefined, those ports and counters
//   are absent.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high reset
//   pc_write       in   1   1 = PC may advance, 0 = hold PC
//   if_id_write    in   1   1 = IF/ID may load, 0 = hold IF/ID
//   branch_taken   in   1   EX stage redirect request
//   branch_target  in   32  redirect address (low two bits ignored)
//   instruction    in   32  memory word at pc (same cycle)
//   pc             out  32  current fetch address
//   if_id_pc       out  32  PC of the instruction held in IF/ID
//   if_id_instr    out  32  instruction held in IF/ID
//   if_id_valid    out  1   IF/ID holds a real instruction
//   halted         out  1   program finished or fetch fault (sticky)
//   fetch_fault    out  1   out-of-range fetch detected (sticky)
//   perf_fetched   out  32  (FETCH_PERF_EN) valid IF/ID loads
//   perf_stalls    out  32  (FETCH_PERF_EN) RUN edges with PC held, no redirect
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXIT_WORD    = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MEM_DEPTH    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Word index limit and drain preload, sized to their comparison targets.
  localparam logic [29:0] MEM_DEPTH_W = MEM_DEPTH[29:0];
  localparam logic [3:0]  DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  drain_cnt_r;
  logic        fault_addr_s;
  logic        exit_s;

  // Out-of-range fetch and EXIT detection on the word currently addressed.
  assign fault_addr_s = (pc[31:2] >= MEM_DEPTH_W);
  assign exit_s       = (instruction == EXIT_WORD);

  // Fetch sequencing: PC, IF/ID register, drain countdown and sticky status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= 4'd0;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (branch_taken) begin
            // The flush overrides an if_id_write hold.
            pc          <= branch_target & 32'hFFFF_FFFC;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
          end else if (fault_addr_s) begin
            fetch_fault <= 1'b1;
            halted      <= 1'b1;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            state_r     <= ST_HALTED;
          end else if (exit_s) begin
            // EXIT is never issued. Bubbles flow while older work retires.
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            drain_cnt_r <= DRAIN_LOAD;
            state_r     <= ST_DRAIN;
          end else begin
            if (pc_write) begin
              pc <= pc + 32'd4;
            end
            // If pc_write=0 with if_id_write=1, the same word is reloaded.
            if (if_id_write) begin
              if_id_pc    <= pc;
              if_id_instr <= instruction;
              if_id_valid <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if_id_pc    <= 32'h0000_0000;
          if_id_instr <= NOP_WORD;
          if_id_valid <= 1'b0;
          if (branch_taken) begin
            // An older branch resolving cancels the drain. Fetch restarts.
            pc      <= branch_target & 32'hFFFF_FFFC;
            state_r <= ST_RUN;
          end else if (drain_cnt_r == 4'd0) begin
            halted  <= 1'b1;
            state_r <= ST_HALTED;
          end else begin
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          // An unreachable encoding parks the block in the safe halted state.
          halted  <= 1'b1;
          state_r <= ST_HALTED;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetched_s;
  logic stalled_s;

  // Event strobes for the counters. Neither strobe can fire outside RUN,
  // so the counters freeze in DRAIN (no fetch) and in HALTED.
  assign fetched_s = (state_r == ST_RUN) && !branch_taken && !fault_addr_s &&
                     !exit_s && if_id_write;
  assign stalled_s = (state_r == ST_RUN) && !branch_taken && !pc_write;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0000_0000;
      perf_stalls  <= 32'h0000_0000;
    end else begin
      if (fetched_s && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stalled_s && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
